// File: rtl/decoder_n_scan_pkg.sv
// Shared types and helpers for the registered one-hot decoder with auto-scan.
// The one-hot helper is sized for the widest supported select; callers truncate.
package dec_pkg;

  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  function automatic int out_width(input int sel_w);
    return 2 ** sel_w;
  endfunction

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] code);
    logic [MAX_OUT_W-1:0] v;
    v = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_n_scan_if.sv
// Control and output bundle between the driving control logic and the decoder.
interface decoder_n_scan_if #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) ();

  localparam int OUT_W = 2 ** SEL_W;

  logic               enable;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   y;
  logic [SEL_W-1:0]   code_out;
  logic               wrap;

  modport master (
    output enable, mode, sel, dwell,
    input  y, code_out, wrap
  );

  modport slave (
    input  enable, mode, sel, dwell,
    output y, code_out, wrap
  );

endinterface

// File: rtl/decoder_n_scan_dwell_timer.sv
// Per-position hold counter; expire is high once the count has reached dwell.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);

  logic [DWELL_W-1:0] count_q;

  // Using >= means a dwell lowered below the running count expires next edge.
  assign expire = (count_q >= dwell);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (run) begin
      count_q <= expire ? '0 : count_q + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/decoder_n_scan.sv
// Registered N-to-2^N one-hot decoder with direct-select and auto-scan modes.
module decoder_n_scan
  import dec_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  decoder_n_scan_if.slave   bus
);

  localparam int OUT_W = out_width(SEL_W);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_DIRECT = DIRECT;
  localparam logic [1:0] ST_SCAN   = SCAN;

  logic [1:0]       state_q, state_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic [SEL_W-1:0] code_q, code_d;
  logic             wrap_q, wrap_d;
  logic             tmr_clear, tmr_run, expire;

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .run    (tmr_run),
    .dwell  (bus.dwell),
    .expire (expire)
  );

  // The timer only runs while scanning continues; any entry into SCAN starts from a zero count.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    code_d    = code_q;
    wrap_d    = 1'b0;
    tmr_clear = 1'b1;
    tmr_run   = 1'b0;
    if (!bus.enable) begin
      state_d = ST_IDLE;
      y_d     = '0;
      code_d  = '0;
    end else if (!bus.mode) begin
      state_d = ST_DIRECT;
      code_d  = bus.sel;
      y_d     = OUT_W'(onehot(MAX_SEL_W'(bus.sel)));
    end else if (state_q != ST_SCAN) begin
      state_d = ST_SCAN;
      code_d  = '0;
      y_d     = OUT_W'(1);
    end else begin
      tmr_clear = 1'b0;
      tmr_run   = 1'b1;
      if (expire) begin
        code_d = code_q + SEL_W'(1);
        y_d    = OUT_W'(onehot(MAX_SEL_W'(code_d)));
        wrap_d = (code_q == '1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      code_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      code_q  <= code_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.y        = y_q;
  assign bus.code_out = code_q;
  assign bus.wrap     = wrap_q;

endmodule
